// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, reset PC and fetch FSM encoding for the instruction fetch unit.
// Global defines are kept here so every file of the fetch slice sees the same values.
`ifndef INST_FETCH_UNIT_DEFINES
`define INST_FETCH_UNIT_DEFINES
`define CPU_WIDTH 32
`define RESET_PC_VALUE 32'h0000_0100
`define INST_NOP 32'h0000_0013
`endif

package inst_fetch_unit_pkg;

  localparam int CPU_WIDTH = `CPU_WIDTH;
  localparam logic [CPU_WIDTH-1:0] RESET_PC_VALUE = `RESET_PC_VALUE;
  localparam logic [CPU_WIDTH-1:0] INST_NOP = `INST_NOP;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [CPU_WIDTH-1:0] align_word(input logic [CPU_WIDTH-1:0] addr);
    return {addr[CPU_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs, with flush and a
// registered head so decode sees stable data straight from flops.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             pop_ok;
  logic             push_ok;
  logic             write_en;

  always_comb begin
    pop_ok      = pop && (count_reg != '0);
    push_ok     = push && ((count_reg != DEPTH_CNT) || pop_ok);
    rd_ptr_next = pop_ok  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    wr_ptr_next = push_ok ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    count_next  = count_reg;
    if (push_ok && !pop_ok) count_next = count_reg + CW'(1);
    if (!push_ok && pop_ok) count_next = count_reg - CW'(1);
    // The new head is the word being written whenever it lands on the next read slot.
    if (push_ok && (wr_ptr_reg == rd_ptr_next)) head_next = push_data;
    else                                        head_next = mem_reg[rd_ptr_next];
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
      head_next   = '0;
    end
  end

  assign write_en = push_ok && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (write_en && (wr_ptr_reg == PW'(gi))) mem_reg[gi] <= push_data;
      end
    end
  endgenerate

  assign count     = count_reg;
  assign head_data = head_reg;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch-side initiator: owns the PC, captures zero-latency instruction memory
// data into a small buffer and hands {pc, inst} to decode via valid/ready.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                   BUF_DEPTH = 2,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = RESET_PC_VALUE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [CPU_WIDTH-1:0] pc_addr_o,
  input  logic [CPU_WIDTH-1:0] inst_i,
  input  logic                 redirect_i,
  input  logic [CPU_WIDTH-1:0] redirect_pc_i,
  output logic                 if_valid_o,
  input  logic                 if_ready_i,
  output logic [CPU_WIDTH-1:0] if_pc_o,
  output logic [CPU_WIDTH-1:0] if_inst_o
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);

  fetch_state_t           state_reg, state_next;
  logic [CPU_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0]          count;
  logic [2*CPU_WIDTH-1:0] head_data;
  logic                   pop;
  logic                   capture;
  logic                   full_next;

  assign if_valid_o = (count != '0);
  assign pop        = if_valid_o && if_ready_i;
  assign pc_addr_o  = fetch_pc_reg;
  assign if_pc_o    = head_data[2*CPU_WIDTH-1:CPU_WIDTH];
  assign if_inst_o  = head_data[CPU_WIDTH-1:0];

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    capture       = 1'b0;
    full_next     = 1'b0;
    case (state_reg)
      BOOT: state_next = FETCH;
      FETCH, FULL: begin
        // A pop frees a slot in the same cycle, so a full buffer keeps streaming.
        capture    = (count != DEPTH_CNT) || pop;
        full_next  = ((count == DEPTH_CNT) && !pop) ||
                     ((count == DEPTH_CNT - CW'(1)) && capture && !pop);
        state_next = full_next ? FULL : FETCH;
      end
      default: state_next = BOOT;
    endcase
    if (capture) fetch_pc_next = fetch_pc_reg + CPU_WIDTH'(4);
    if (redirect_i) begin
      capture       = 1'b0;
      state_next    = FETCH;
      fetch_pc_next = align_word(redirect_pc_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= BOOT;
      fetch_pc_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  if_fifo #(
    .WIDTH (2 * CPU_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_if_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data ({fetch_pc_reg, inst_i}),
    .pop       (pop),
    .flush     (redirect_i),
    .count     (count),
    .head_data (head_data)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit, checked every cycle against a queue-level model.
// Instruction memory is a combinational function of the fetch address.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = RESET_PC_VALUE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_addr;
  logic [31:0] inst;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]} ^ 32'h5A00_0000;
  endfunction

  assign inst = mem_word(pc_addr);

  inst_fetch_unit #(
    .BUF_DEPTH (DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_addr_o     (pc_addr),
    .inst_i        (inst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .if_valid_o    (if_valid),
    .if_ready_i    (if_ready),
    .if_pc_o       (if_pc),
    .if_inst_o     (if_inst)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: fetch PC, boot flag and an ordered queue of buffered {pc, inst}.
  logic [31:0] m_pc = RST_PC;
  bit          m_boot = 1'b1;
  bit          m_known = 1'b0;
  bit          m_just_reset = 1'b0;
  logic [63:0] m_q[$];

  task automatic compare_outputs();
    logic [63:0] h;
    check("pc_addr", pc_addr, m_pc);
    check("if_valid", {31'b0, if_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      h = m_q[0];
      check("if_pc", if_pc, h[63:32]);
      check("if_inst", if_inst, h[31:0]);
    end else if (m_just_reset) begin
      check("reset_if_pc", if_pc, 32'h0);
      check("reset_if_inst", if_inst, 32'h0);
    end
  endtask

  task automatic model_update(input logic r, input logic rdy, input logic redir,
                              input logic [31:0] tgt);
    logic [63:0] h;
    m_just_reset = 1'b0;
    if (!r) begin
      m_pc = RST_PC;
      m_q.delete();
      m_boot = 1'b1;
      m_just_reset = 1'b1;
    end else if (redir) begin
      m_q.delete();
      m_pc = {tgt[31:2], 2'b00};
      m_boot = 1'b0;
    end else begin
      if (m_q.size() != 0 && rdy) begin
        h = m_q.pop_front();
        $display("[TB] decode took pc=%h inst=%h", h[63:32], h[31:0]);
      end
      if (!m_boot && m_q.size() < DEPTH) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic redir, input logic [31:0] tgt);
    @(negedge clk);
    if (m_known) compare_outputs();
    rst_n       = r;
    if_ready    = rdy;
    redirect    = redir;
    redirect_pc = tgt;
    @(posedge clk);
    model_update(r, rdy, redir, tgt);
    m_known = 1'b1;
  endtask

  initial begin
    logic        r, rdy, redir;
    logic [31:0] tgt;

    // reset, then free-running stream
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // backpressure then release
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // redirect while full
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, RST_PC + 32'h40);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // misaligned target
    step(1'b1, 1'b1, 1'b1, RST_PC + 32'h43);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // redirect coincident with pop on a full buffer
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, RST_PC + 32'h80);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // address wrap
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // reset mid-stream with a full buffer
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // redirect during boot
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, RST_PC + 32'h200);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      r     = ($urandom_range(0, 99) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(r, rdy, redir, tgt);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
